// File: rtl/mips16_byte_tx.sv
// mips16_byte_tx: FIFO-buffered 16-bit word transmitter, high byte first,
// over an 8-bit lane with a 4-phase req/ack handshake to an async host.
module mips16_byte_tx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t                 r_state;
  logic [15:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wp, r_rp;
  logic [AW:0]            r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [15:0]            r_word;
  logic                   r_hi_done;
  logic                   w_full, w_push, w_pop, w_ack_s;
  assign w_full   = r_cnt == (AW+1)'(DEPTH);
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = r_state == IDLE && r_cnt != '0;
  assign w_ack_s  = r_sync[SYNC_STAGES-1];
  assign busy     = r_cnt != '0 || r_state != IDLE;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_sync    <= '0;
      r_word    <= '0;
      r_hi_done <= 1'b0;
      tx_data   <= 8'h00;
      tx_req    <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tx_ack};
      r_wp   <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp   <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (in_valid && !in_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      // tx_data only ever changes on the edge that raises tx_req
      case (r_state)
        IDLE: if (w_pop) begin
          r_word    <= r_mem[r_rp];
          tx_data   <= r_mem[r_rp][15:8];
          tx_req    <= 1'b1;
          r_hi_done <= 1'b0;
          r_state   <= REQ;
        end
        REQ: if (w_ack_s) begin
          tx_req  <= 1'b0;
          r_state <= REL;
        end
        REL: if (!w_ack_s) begin
          if (!r_hi_done) begin
            tx_data   <= r_word[7:0];
            tx_req    <= 1'b1;
            r_hi_done <= 1'b1;
            r_state   <= REQ;
          end else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips16_byte_tx.sv
// tb_mips16_byte_tx: directed stimulus with a byte-stream/occupancy model
// checked every cycle, plus literal expectations per scenario.
module tb_mips16_byte_tx;
  localparam int DEPTH = 4;
  logic        clk, rst, in_valid, in_ready, tx_req, tx_ack, busy;
  logic [15:0] in_data;
  logic [7:0]  tx_data, drop_cnt;
  int n_chk = 0, n_fail = 0;
  logic       host_en = 1'b0, man_ack = 1'b0, auto_ack = 1'b0;
  int         ack_dly = 1, host_cnt = 0;
  logic [7:0] m_bytes[$];
  logic [7:0] rx_log[$];
  int         m_cnt = 0, m_drop = 0;
  logic       m_hi = 1'b1, pend_push = 1'b0, pend_drop = 1'b0, pend_rst = 1'b1;
  logic       prev_req = 1'b0;
  logic [7:0] prev_data = 8'h00;

  mips16_byte_tx #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // host: auto mode acks ack_dly cycles after each req change, else follows man_ack
  initial begin
    tx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!host_en) begin
        auto_ack = man_ack;
        host_cnt = 0;
      end else if (tx_req != auto_ack) begin
        if (host_cnt >= ack_dly) begin
          auto_ack = tx_req;
          host_cnt = 0;
        end else host_cnt++;
      end else host_cnt = 0;
      tx_ack = host_en ? auto_ack : man_ack;
    end
  end

  // model: expected byte stream and FIFO occupancy derived from offers and req rises
  initial begin
    forever begin
      @(negedge clk);
      if (pend_rst) begin
        m_bytes.delete();
        m_cnt  = 0;
        m_drop = 0;
        m_hi   = 1'b1;
        chk("req_after_rst", tx_req, 0);
      end else begin
        if (tx_req && !prev_req) begin
          rx_log.push_back(tx_data);
          if (m_bytes.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_extra: got byte %0h expected none", tx_data);
          end else chk("rx_byte", tx_data, m_bytes.pop_front());
          if (m_hi) m_cnt--;
          m_hi = !m_hi;
        end
        m_cnt += int'(pend_push);
        if (pend_drop && m_drop < 255) m_drop++;
        if (prev_req && tx_req) chk("tx_data_stable", tx_data, prev_data);
      end
      chk("in_ready", in_ready, !rst && m_cnt < DEPTH);
      chk("drop_cnt", drop_cnt, m_drop);
      pend_push = in_valid && !rst && m_cnt < DEPTH;
      pend_drop = in_valid && !rst && m_cnt >= DEPTH;
      if (pend_push) begin
        m_bytes.push_back(in_data[15:8]);
        m_bytes.push_back(in_data[7:0]);
      end
      pend_rst  = rst;
      prev_req  = tx_req;
      prev_data = tx_data;
    end
  end

  task automatic push(input logic [15:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic v, input string nm);
    for (int i = 0; i < 400 && tx_req !== v; i++) begin
      @(posedge clk);
      #3;
    end
    chk(nm, tx_req, v);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) begin
      @(posedge clk);
      #3;
    end
    chk(nm, busy, 0);
  endtask

  task automatic set_ack(input logic v);
    man_ack = v;
    @(posedge clk);
    #3;
  endtask

  task automatic count_to(input logic v, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while (tx_req !== v && n < 50);
  endtask

  initial begin
    int  n;
    logic ok;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    // reset held with a word offered
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    // single word, latency and byte order
    host_en = 1'b1;
    ack_dly = 1;
    rx_log.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 16'hA55A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_req_E", tx_req, 0);
    chk("lat_busy_E", busy, 1);
    @(negedge clk);
    chk("lat_req_E1", tx_req, 1);
    chk("lat_data_E1", tx_data, 8'hA5);
    wait_idle("single_idle");
    chk("single_n", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      chk("single_b0", rx_log[0], 8'hA5);
      chk("single_b1", rx_log[1], 8'h5A);
    end
    // burst through a slow host: pointer wrap and one drop
    ack_dly = 20;
    rx_log.delete();
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      #1;
      in_valid = 1'b1;
      in_data = 16'(i);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    #2;
    chk("burst_drop", drop_cnt, 1);
    chk("burst_full", in_ready, 0);
    wait_idle("burst_idle");
    chk("burst_n", rx_log.size(), 10);
    if (rx_log.size() == 10)
      for (int i = 0; i < 10; i++)
        chk("burst_byte", rx_log[i], (i % 2) ? i / 2 + 1 : 0);
    // drop counter saturation on a stalled host
    host_en = 1'b0;
    man_ack = 1'b0;
    rx_log.delete();
    @(posedge clk);
    for (int i = 0; i < 305; i++) begin
      #1;
      in_valid = 1'b1;
      in_data = 16'h1000 + 16'(i);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    #2;
    chk("sat_drop", drop_cnt, 255);
    host_en = 1'b1;
    ack_dly = 0;
    wait_idle("sat_idle");
    chk("sat_first", rx_log.size() > 0 ? rx_log[0] : -1, 8'h10);
    // ack held high across end of word, then handshake response timing
    host_en = 1'b0;
    push(16'hC3D4);
    push(16'hE5F6);
    wait_req(1, "held_req_hi");
    chk("held_hi", tx_data, 8'hC3);
    set_ack(1);
    wait_req(0, "held_fall_hi");
    set_ack(0);
    wait_req(1, "held_req_lo");
    chk("held_lo", tx_data, 8'hD4);
    set_ack(1);
    wait_req(0, "held_fall_lo");
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #3;
      if (tx_req) ok = 1'b0;
    end
    chk("held_no_req", ok, 1);
    set_ack(0);
    count_to(1, n);
    chk("next_word_edges", n, 4);
    chk("next_word_hi", tx_data, 8'hE5);
    set_ack(1);
    count_to(0, n);
    chk("req_fall_edges", n, 3);
    set_ack(0);
    count_to(1, n);
    chk("lo_rise_edges", n, 3);
    chk("lo_byte", tx_data, 8'hF6);
    set_ack(1);
    wait_req(0, "f6_fall");
    set_ack(0);
    wait_idle("held_idle");
    // one-cycle ack glitch advances exactly once
    push(16'h1122);
    wait_req(1, "gl_req");
    chk("gl_hi", tx_data, 8'h11);
    set_ack(1);
    set_ack(0);
    repeat (10) @(posedge clk);
    #3;
    chk("gl_req_lo", tx_req, 1);
    chk("gl_lo", tx_data, 8'h22);
    set_ack(1);
    wait_req(0, "gl_fall");
    set_ack(0);
    wait_idle("gl_idle");
    // reset during the low-byte request
    push(16'hBEEF);
    wait_req(1, "mr_req_hi");
    set_ack(1);
    wait_req(0, "mr_fall");
    set_ack(0);
    wait_req(1, "mr_req_lo");
    chk("mr_lo", tx_data, 8'hEF);
    rst = 1'b1;
    @(posedge clk);
    #3;
    chk("mr_req", tx_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_drop", drop_cnt, 0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #3;
      if (tx_req || busy) ok = 1'b0;
    end
    chk("mr_quiet", ok, 1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
